mem_loader: RTL and testbench

- Host-side loader directly upstream of the main_mem write port.
- Accepts a byte stream over a valid/ready handshake and writes it to consecutive main_mem addresses, starting from a programmed first address, for a programmed word count.
- Replaces manual pre-loading of inputs, W1 and W2. Its write outputs feed the main_mem write-port mux while the system is not started.

---
 rtl/mem_loader_pkg.sv | 24 ++
 rtl/mem_loader.sv | 167 ++++++++++++++++
 tb/tb_mem_loader.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_loader_pkg.sv
// Shared definitions for the host-side main_mem loader.
// Holds the loader FSM states, the main_mem geometry defaults (shared with
// main_mem/dmac) and the first addresses of each region in the memory map.
package mem_loader_pkg;

  // main_mem geometry
  localparam int ELEMENT_BITS     = 8;
  localparam int MAIN_MEM_ADD_LEN = 11;
  localparam int MAIN_MEM_DEPTH   = 2048;

  // Memory map: first word of each region
  localparam int IN_FIRST  = 0;
  localparam int W1_FIRST  = 40;
  localparam int W2_FIRST  = 104;
  localparam int OUT_FIRST = 168;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_loader.sv
// Purpose : streams bytes from a valid/ready source into consecutive main_mem
//           words, starting at a programmed address, for a programmed count.
// Latency : a word accepted in cycle N is written (mem_we/address/data) in N+1.
// Backpr. : s_ready is high only in LOAD/CHECK; the loader waits indefinitely on
//           s_valid gaps and drops s_ready the cycle after the last word.
//
// Ports:
//   fpga_clk, reset_n           clock, asynchronous active-low reset
//   load_start                  one-cycle pulse starting a job (honoured in IDLE only)
//   load_first_address          first write address, sampled on load_start
//   load_count                  number of words to write, sampled on load_start
//   s_valid, s_data, s_ready    input byte stream handshake
//   mem_we, mem_address,        registered main_mem write port
//   mem_data
//   busy, done, err             job active, end-of-job pulse, sticky checksum error
//
// Build option MEM_LOADER_CHECKSUM_EN: after the data words one extra stream
// word is accepted and compared with the mod-2^ELEMENT_BITS sum of the written
// words; a mismatch sets err until the next accepted load_start. Without the
// option there is no CHECK state and err is tied low.
module mem_loader #(
  parameter int ELEMENT_BITS     = mem_loader_pkg::ELEMENT_BITS,
  parameter int MAIN_MEM_ADD_LEN = mem_loader_pkg::MAIN_MEM_ADD_LEN,
  parameter int MAIN_MEM_DEPTH   = mem_loader_pkg::MAIN_MEM_DEPTH
) (
  input  logic                        fpga_clk,
  input  logic                        reset_n,
  input  logic                        load_start,
  input  logic [MAIN_MEM_ADD_LEN-1:0] load_first_address,
  input  logic [MAIN_MEM_ADD_LEN-1:0] load_count,
  input  logic                        s_valid,
  input  logic [ELEMENT_BITS-1:0]     s_data,
  output logic                        s_ready,
  output logic                        mem_we,
  output logic [MAIN_MEM_ADD_LEN-1:0] mem_address,
  output logic [ELEMENT_BITS-1:0]     mem_data,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  import mem_loader_pkg::*;

  state_e                      state_q, state_d;
  logic [MAIN_MEM_ADD_LEN-1:0] cur_addr_q, cur_addr_d;
  logic [MAIN_MEM_ADD_LEN-1:0] remaining_q, remaining_d;
  logic                        mem_we_q, mem_we_d;
  logic [MAIN_MEM_ADD_LEN-1:0] mem_address_q, mem_address_d;
  logic [ELEMENT_BITS-1:0]     mem_data_q, mem_data_d;
  logic [MAIN_MEM_ADD_LEN-1:0] next_addr;

`ifdef MEM_LOADER_CHECKSUM_EN
  logic                        err_q, err_d;
  logic [ELEMENT_BITS-1:0]     sum_q, sum_d;
`endif

  // Wrap by comparison so a first address at or beyond the depth still
  // returns to 0 on the next increment.
  assign next_addr = (int'(cur_addr_q) >= MAIN_MEM_DEPTH - 1) ? '0 : cur_addr_q + 1'b1;

  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      mem_we_q      <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
      err_q         <= 1'b0;
      sum_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      mem_we_q      <= mem_we_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
`ifdef MEM_LOADER_CHECKSUM_EN
      err_q         <= err_d;
      sum_q         <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    mem_we_d      = 1'b0;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    s_ready       = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
    err_d         = err_q;
    sum_d         = sum_q;
`endif

    case (state_q)
      IDLE: begin
        if (load_start) begin
          cur_addr_d  = load_first_address;
          remaining_d = load_count;
`ifdef MEM_LOADER_CHECKSUM_EN
          err_d       = 1'b0;
          sum_d       = '0;
          // An empty job still expects a checksum word (of value 0).
          state_d     = (load_count == '0) ? CHECK : LOAD;
`else
          state_d     = (load_count == '0) ? DONE : LOAD;
`endif
        end
      end

      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          mem_we_d      = 1'b1;
          mem_address_d = cur_addr_q;
          mem_data_d    = s_data;
          cur_addr_d    = next_addr;
          remaining_d   = remaining_q - 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
          sum_d         = sum_q + s_data;
          if (remaining_q == MAIN_MEM_ADD_LEN'(1)) state_d = CHECK;
`else
          if (remaining_q == MAIN_MEM_ADD_LEN'(1)) state_d = DONE;
`endif
        end
      end

`ifdef MEM_LOADER_CHECKSUM_EN
      CHECK: begin
        // Checksum word is consumed but never written to memory.
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          err_d   = (s_data != sum_q);
          state_d = DONE;
        end
      end
`endif

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign mem_we      = mem_we_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;

`ifdef MEM_LOADER_CHECKSUM_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;
  import mem_loader_pkg::*;

  logic        fpga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_start = 1'b0;
  logic [10:0] load_first_address = '0;
  logic [10:0] load_count = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, mem_we, busy, done, err;
  logic [10:0] mem_address;
  logic [7:0]  mem_data;

  mem_loader dut (
    .fpga_clk(fpga_clk), .reset_n(reset_n), .load_start(load_start),
    .load_first_address(load_first_address), .load_count(load_count),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_address(mem_address), .mem_data(mem_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 fpga_clk = ~fpga_clk;

  int          n_assert = 0;
  int          n_fail = 0;
  // Written only by the monitor
  int          lat_err = 0;
  int          done_cnt = 0;
  logic        prev_hs = 1'b0;
  logic [18:0] act_q[$];
  logic [7:0]  dut_mem[MAIN_MEM_DEPTH];
  // Written only by the stimulus block
  logic [18:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  ref_mem[MAIN_MEM_DEPTH];
  int          act_base, lat_base, done_base, busy_drop;
  logic        timed_out, exp_err, err_after_start;

  // Observe the write port: every write must follow a handshake seen in the
  // previous cycle and vice versa; writes are logged for the scoreboard.
  always @(negedge fpga_clk) begin
    if (!reset_n) begin
      prev_hs = 1'b0;
    end else begin
      if (mem_we === 1'b1) begin
        act_q.push_back({mem_address, mem_data});
        dut_mem[mem_address] = mem_data;
      end
      if (mem_we !== prev_hs) lat_err++;
      if (done === 1'b1) done_cnt++;
      prev_hs = s_valid && s_ready;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge fpga_clk);
    #1;
  endtask

  // Reference: word i of a job lands at (first + i) mod depth.
  function automatic void model_job(input int first);
    logic [10:0] a;
    exp_q.delete();
    for (int i = 0; i < tx_q.size(); i++) begin
      a = 11'((first + i) % MAIN_MEM_DEPTH);
      exp_q.push_back({a, tx_q[i]});
      ref_mem[a] = tx_q[i];
    end
  endfunction

  function automatic logic [7:0] model_sum();
    int s = 0;
    foreach (tx_q[i]) s += int'(tx_q[i]);
    return 8'(s % 256);
  endfunction

  // mode: 0 = always valid, 1 = valid on alternate cycles, 2 = random gaps.
  // inject_cyc >= 0 pulses a stray load_start in that cycle of the job.
  task automatic run_job(input int first, input int mode, input int inject_cyc, input logic [7:0] ck_word);
    int cnt, n_words, idx, cyc;
    cnt = tx_q.size();
    model_job(first);
    act_base = act_q.size();
    lat_base = lat_err;
    done_base = done_cnt;
    busy_drop = 0;
`ifdef MEM_LOADER_CHECKSUM_EN
    n_words = cnt + 1;
    exp_err = (ck_word != model_sum());
`else
    n_words = cnt;
    exp_err = 1'b0;
`endif
    load_first_address = 11'(first);
    load_count = 11'(cnt);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    err_after_start = err;
    idx = 0;
    cyc = 0;
    while (idx < n_words && cyc < 4000) begin
      s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      s_data = (idx < cnt) ? tx_q[idx] : ck_word;
      if (cyc == inject_cyc) begin
        load_start = 1'b1;
        load_first_address = 11'd5;
        load_count = 11'd3;
      end else begin
        load_start = 1'b0;
      end
      @(negedge fpga_clk);
      if (busy !== 1'b1) busy_drop++;
      if (s_valid && s_ready) idx++;
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    load_start = 1'b0;
    timed_out = (idx < n_words);
    repeat (3) tick();
  endtask

  task automatic check_job(input string tag);
    int n;
    check({tag, " timeout"}, timed_out, 0);
    n = act_q.size() - act_base;
    check({tag, " write count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check($sformatf("%s write %0d", tag, i), act_q[act_base + i], exp_q[i]);
    check({tag, " latency"}, lat_err - lat_base, 0);
    check({tag, " done pulses"}, done_cnt - done_base, 1);
    check({tag, " busy held"}, busy_drop, 0);
    check({tag, " idle s_ready"}, s_ready, 0);
    check({tag, " idle busy"}, busy, 0);
    check({tag, " err cleared on start"}, err_after_start, 0);
    check({tag, " err"}, err, exp_err);
  endtask

  initial begin
    int idx, cyc;

    // Reset state
    repeat (2) tick();
    check("reset mem_we", mem_we, 0);
    check("reset mem_address", mem_address, 0);
    check("reset mem_data", mem_data, 0);
    check("reset s_ready", s_ready, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    reset_n = 1'b1;
    tick();

    // W1 region load with fixed pattern, back-to-back stream
    tx_q.delete();
    for (int i = 0; i < 20; i++) tx_q.push_back(8'h86);
    for (int i = 0; i < 20; i++) tx_q.push_back(8'h08);
    for (int i = 0; i < 24; i++) tx_q.push_back(8'h07);
    run_job(W1_FIRST, 0, -1, model_sum());
    check_job("w1");
    for (int a = W1_FIRST; a < W1_FIRST + 64; a++)
      check($sformatf("w1 readback %0d", a), dut_mem[a], ref_mem[a]);

    // Address wrap at the top of memory
    tx_q = '{8'h36, 8'h37, 8'h38, 8'h39};
    run_job(2046, 0, -1, model_sum());
    check_job("wrap");

    // Alternating valid
    tx_q.delete();
    for (int i = 0; i < 16; i++) tx_q.push_back(8'($urandom));
    run_job(IN_FIRST, 1, -1, model_sum());
    check_job("backpressure");

    // Empty job
    tx_q.delete();
    run_job(OUT_FIRST, 0, -1, 8'h00);
    check_job("zero count");

    // Stray load_start mid-job must not disturb it
    tx_q.delete();
    for (int i = 0; i < 12; i++) tx_q.push_back(8'($urandom));
    run_job(W2_FIRST, 2, 4, model_sum());
    check_job("ignored start");

    // Random jobs
    for (int j = 0; j < 4; j++) begin
      tx_q.delete();
      for (int i = 0, n = $urandom_range(1, 40); i < n; i++) tx_q.push_back(8'($urandom));
      run_job($urandom_range(0, MAIN_MEM_DEPTH - 1), 2, -1, model_sum());
      check_job($sformatf("random %0d", j));
    end

    // Reset after 5 of 10 words; a handshake is pending when reset hits
    tx_q.delete();
    for (int i = 0; i < 5; i++) tx_q.push_back(8'($urandom));
    model_job(300);
    for (int i = 0; i < 5; i++) tx_q.push_back(8'($urandom));
    act_base = act_q.size();
    lat_base = lat_err;
    done_base = done_cnt;
    load_first_address = 11'd300;
    load_count = 11'd10;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    idx = 0;
    cyc = 0;
    s_valid = 1'b1;
    while (idx < 5 && cyc < 100) begin
      s_data = tx_q[idx];
      @(negedge fpga_clk);
      if (s_valid && s_ready) idx++;
      tick();
      cyc++;
    end
    check("reset job timeout", idx, 5);
    s_data = tx_q[5];
    @(negedge fpga_clk);
    #1 reset_n = 1'b0;
    #1;
    check("midreset mem_we", mem_we, 0);
    check("midreset mem_address", mem_address, 0);
    check("midreset mem_data", mem_data, 0);
    check("midreset s_ready", s_ready, 0);
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    s_valid = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    check("post reset s_ready", s_ready, 0);
    check("post reset busy", busy, 0);
    check("post reset mem_we", mem_we, 0);
    check("reset job write count", act_q.size() - act_base, exp_q.size());
    for (int i = 0; i < exp_q.size() && act_base + i < act_q.size(); i++)
      check($sformatf("reset job write %0d", i), act_q[act_base + i], exp_q[i]);
    check("reset job latency", lat_err - lat_base, 0);
    check("reset job no done", done_cnt - done_base, 0);

    tx_q.delete();
    for (int i = 0; i < 2; i++) tx_q.push_back(8'($urandom));
    run_job(200, 0, -1, model_sum());
    check_job("after reset");

`ifdef MEM_LOADER_CHECKSUM_EN
    tx_q = '{8'h10, 8'h20, 8'h30};
    check("checksum model", model_sum(), 8'h60);
    run_job(IN_FIRST, 0, -1, 8'h60);
    check_job("checksum good");
    run_job(IN_FIRST, 0, -1, 8'h61);
    check_job("checksum bad");
    tx_q = '{8'h55};
    run_job(OUT_FIRST, 2, -1, 8'h55);
    check_job("checksum clear");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
